// File: rtl/counter_unit_if.sv
// Control/status bundle for one counter channel.
// master = the side that programs the channel, slave = the counter itself.
interface counter_unit_if #(
    parameter int WIDTH = 16,
    parameter int EVT_W = 8
);
    logic             i_start;
    logic             i_stop;
    logic             i_oneshot;
    logic [1:0]       i_out_mode;
    logic [WIDTH-1:0] i_top;
    logic [WIDTH-1:0] i_cmp;
    logic             i_evt_clr;
    logic [WIDTH-1:0] o_cnt;
    logic             o_busy;
    logic             o_wrap;
    logic             o_done;
    logic             o_douta;
    logic [EVT_W-1:0] o_evt_cnt;

    modport master (
        output i_start, i_stop, i_oneshot, i_out_mode, i_top, i_cmp, i_evt_clr,
        input  o_cnt, o_busy, o_wrap, o_done, o_douta, o_evt_cnt
    );

    modport slave (
        input  i_start, i_stop, i_oneshot, i_out_mode, i_top, i_cmp, i_evt_clr,
        output o_cnt, o_busy, o_wrap, o_done, o_douta, o_evt_cnt
    );
endinterface

// File: rtl/counter_unit.sv
// One counter channel: counts 0..i_top, flags wraps, counts wrap events and
// drives a registered waveform (hold / toggle / PWM / pulse) on o_douta.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | stopped; o_cnt and o_douta hold their values
//   ST_RUN  | counting; o_busy=1
module counter_unit #(
    parameter int WIDTH = 16,
    parameter int EVT_W = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    counter_unit_if.slave  bus
);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_PWM    = 2'b10;
    localparam logic [1:0] MODE_PULSE  = 2'b11;

    state_t           state, state_next;
    logic [WIDTH-1:0] cnt, cnt_next;
    logic             busy, busy_next;
    logic             wrap, wrap_next;
    logic             done, done_next;
    logic             douta, douta_next;
    logic [EVT_W-1:0] evt, evt_next;

    // A wrap only counts when nothing else (stop or restart) claims the cycle.
    // Using >= lets a live lowering of i_top below the count wrap at once.
    logic run_free;
    logic wrap_evt;
    assign run_free = (state == ST_RUN) && !bus.i_stop && !bus.i_start;
    assign wrap_evt = run_free && (cnt >= bus.i_top);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic: stop always wins over start.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.i_start && !bus.i_stop) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (bus.i_stop)                        state_next = ST_IDLE;
                else if (wrap_evt && bus.i_oneshot)    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic: next values for every registered output.
    always_comb begin
        cnt_next   = cnt;
        busy_next  = (state_next == ST_RUN);
        wrap_next  = 1'b0;
        done_next  = 1'b0;
        douta_next = douta;
        evt_next   = evt;

        case (state)
            ST_IDLE: begin
                if (bus.i_start && !bus.i_stop) cnt_next = '0;
            end
            ST_RUN: begin
                if (bus.i_stop) begin
                    cnt_next = cnt;
                end else if (bus.i_start) begin
                    cnt_next = '0;
                end else if (wrap_evt) begin
                    cnt_next  = bus.i_oneshot ? cnt : '0;
                    wrap_next = 1'b1;
                    done_next = bus.i_oneshot;
                end else begin
                    cnt_next = cnt + WIDTH'(1);
                end
            end
            default: cnt_next = cnt;
        endcase

        // Waveform only moves while running; a stopping cycle freezes it too.
        if (state == ST_RUN && !bus.i_stop) begin
            case (bus.i_out_mode)
                MODE_HOLD:   douta_next = douta;
                MODE_TOGGLE: douta_next = douta ^ wrap_evt;
                MODE_PWM:    douta_next = (cnt_next < bus.i_cmp);
                MODE_PULSE:  douta_next = wrap_evt;
                default:     douta_next = douta;
            endcase
        end

        // Clear beats a simultaneous wrap; otherwise saturate at all-ones.
        if (bus.i_evt_clr)         evt_next = '0;
        else if (wrap_evt && !(&evt)) evt_next = evt + EVT_W'(1);
    end

    // Output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt   <= '0;
            busy  <= 1'b0;
            wrap  <= 1'b0;
            done  <= 1'b0;
            douta <= 1'b0;
            evt   <= '0;
        end else begin
            cnt   <= cnt_next;
            busy  <= busy_next;
            wrap  <= wrap_next;
            done  <= done_next;
            douta <= douta_next;
            evt   <= evt_next;
        end
    end

    assign bus.o_cnt     = cnt;
    assign bus.o_busy    = busy;
    assign bus.o_wrap    = wrap;
    assign bus.o_done    = done;
    assign bus.o_douta   = douta;
    assign bus.o_evt_cnt = evt;

endmodule
